// File: rtl/arith_ctl.sv
// MIX arithmetic sequencer: fetches a field-selected operand, drives an external
// sign-magnitude adder and writes rA / overflow. Define ARITH_CMP_EN to add CMPA.
module arith_ctl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  command,
  input  logic [5:0]  field,
  input  logic [11:0] address,
  output logic        stop,
  output logic        err,
  output logic        mem_req,
  output logic [11:0] mem_addr,
  input  logic        mem_ack,
  input  logic [30:0] mem_data,
  output logic        add_start,
  output logic [30:0] add_in1,
  output logic [30:0] add_in2,
  input  logic        add_stop,
  input  logic [30:0] add_out,
  input  logic        add_overflow,
  input  logic [30:0] ra_in,
  output logic [30:0] ra_out,
  output logic        ra_we,
  output logic        ovf_set
`ifdef ARITH_CMP_EN
  ,
  output logic [1:0]  cmp_out,
  output logic        cmp_we
`endif
);

  localparam logic [5:0] C_ADD  = 6'd1;
  localparam logic [5:0] C_SUB  = 6'd2;
  localparam logic [5:0] C_CMPA = 6'd56;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WAIT, DONE} state_t;

  state_t      state, state_next;
  logic [5:0]  cmd_reg;
  logic [2:0]  l_reg, r_reg;
  logic [11:0] addr_reg;
  logic [30:0] op1_reg, op2_reg;
  logic        err_reg;

  logic        cmd_ok, field_ok, is_cmp;
  logic [30:0] mem_field, ra_field;

  // Bytes max(L,1)..R right-justified; L=0 also carries the sign.
  function automatic logic [30:0] extract(input logic [30:0] word,
                                          input logic [2:0] l, input logic [2:0] r);
    logic [2:0]  lo, cnt;
    logic [4:0]  sh_r, sh_c;
    logic [29:0] mag, mask;
    lo   = (l == 3'd0) ? 3'd1 : l;
    cnt  = r - lo + 3'd1;
    sh_r = 5'(3'd5 - r) * 5'd6;
    sh_c = 5'(cnt) * 5'd6;
    mag  = word[29:0] >> sh_r;
    mask = ~(30'h3FFF_FFFF << sh_c);
    return {(l == 3'd0) ? word[30] : 1'b0, mag & mask};
  endfunction

`ifdef ARITH_CMP_EN
  assign cmd_ok = (command == C_ADD) || (command == C_SUB) || (command == C_CMPA);
  assign is_cmp = (cmd_reg == C_CMPA);
`else
  assign cmd_ok = (command == C_ADD) || (command == C_SUB);
  assign is_cmp = 1'b0;
`endif

  assign field_ok  = (field[5:3] <= field[2:0]) && (field[2:0] <= 3'd5);
  assign mem_field = extract(mem_data, l_reg, r_reg);
  assign ra_field  = extract(ra_in, l_reg, r_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cmd_reg  <= '0;
      l_reg    <= '0;
      r_reg    <= '0;
      addr_reg <= '0;
      op1_reg  <= '0;
      op2_reg  <= '0;
      err_reg  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        cmd_reg  <= command;
        l_reg    <= field[5:3];
        r_reg    <= field[2:0];
        addr_reg <= address;
        err_reg  <= !(cmd_ok && field_ok);
      end
      // SUB and CMPA both subtract the fetched field.
      if (state == FETCH && mem_ack) begin
        op1_reg <= is_cmp ? ra_field : ra_in;
        op2_reg <= (cmd_reg == C_ADD) ? mem_field : {~mem_field[30], mem_field[29:0]};
      end
    end
  end

  always_comb begin
    state_next = state;
    stop       = 1'b0;
    err        = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    add_start  = 1'b0;
    add_in1    = '0;
    add_in2    = '0;
    ra_out     = '0;
    ra_we      = 1'b0;
    ovf_set    = 1'b0;
`ifdef ARITH_CMP_EN
    cmp_out    = 2'b00;
    cmp_we     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) state_next = (cmd_ok && field_ok) ? FETCH : DONE;
      end
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = addr_reg;
        if (mem_ack) state_next = EXEC;
      end
      EXEC: begin
        add_start  = 1'b1;
        add_in1    = op1_reg;
        add_in2    = op2_reg;
        state_next = WAIT;
      end
      WAIT: begin
        add_in1 = op1_reg;
        add_in2 = op2_reg;
        if (add_stop) begin
          state_next = DONE;
          if (!is_cmp) begin
            ra_we   = 1'b1;
            ra_out  = add_out;
            ovf_set = add_overflow;
          end
`ifdef ARITH_CMP_EN
          else begin
            // +0 and -0 both compare EQUAL.
            cmp_we  = 1'b1;
            cmp_out = (add_out[29:0] == 30'd0) ? 2'b10 : (add_out[30] ? 2'b01 : 2'b11);
          end
`endif
        end
      end
      DONE: begin
        stop       = 1'b1;
        err        = err_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_arith_ctl.sv
// Directed and randomized checks of arith_ctl against an arithmetic reference model;
// the bench also plays memory and sign-magnitude adder.
module tb_arith_ctl;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [5:0]  command, field;
  logic [11:0] address;
  logic        stop, err, mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [30:0] mem_data;
  logic        add_start;
  logic [30:0] add_in1, add_in2;
  logic        add_stop;
  logic [30:0] add_out;
  logic        add_overflow;
  logic [30:0] ra_in, ra_out;
  logic        ra_we, ovf_set;
`ifdef ARITH_CMP_EN
  logic [1:0]  cmp_out;
  logic        cmp_we;
  localparam bit CMPEN = 1'b1;
`else
  wire         cmp_we = 1'b0;
  localparam bit CMPEN = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  arith_ctl dut (
    .clk(clk), .reset(reset), .start(start), .command(command), .field(field),
    .address(address), .stop(stop), .err(err), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .add_start(add_start), .add_in1(add_in1),
    .add_in2(add_in2), .add_stop(add_stop), .add_out(add_out),
    .add_overflow(add_overflow), .ra_in(ra_in), .ra_out(ra_out), .ra_we(ra_we),
    .ovf_set(ovf_set)
`ifdef ARITH_CMP_EN
    , .cmp_out(cmp_out), .cmp_we(cmp_we)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] strobes();
    return {mem_req, add_start, ra_we, ovf_set, cmp_we, stop, err};
  endfunction

  // Reference field value: accumulate bytes lo..R base 64.
  function automatic logic [30:0] fld(input logic [30:0] w, input int l, input int r);
    longint mag = 0;
    longint word = longint'(w[29:0]);
    int lo = (l == 0) ? 1 : l;
    for (int k = lo; k <= r; k++)
      mag = mag * 64 + (word / (64'd1 << (6 * (5 - k)))) % 64;
    return {(l == 0) ? w[30] : 1'b0, 30'(mag)};
  endfunction

  function automatic void sm_add(input logic [30:0] a, input logic [30:0] b,
                                 output logic [30:0] res, output logic ovf);
    longint x = a[30] ? -longint'(a[29:0]) : longint'(a[29:0]);
    longint y = b[30] ? -longint'(b[29:0]) : longint'(b[29:0]);
    longint s = x + y;
    longint m = (s < 0) ? -s : s;
    ovf = (m >= (64'd1 << 30));
    res = {(s < 0) ? 1'b1 : ((s > 0) ? 1'b0 : a[30]), 30'(m % (64'd1 << 30))};
  endfunction

  task automatic run(input string tag, input logic [5:0] cmd, input logic [5:0] f,
                     input logic [11:0] addr, input logic [30:0] ra, input logic [30:0] memw,
                     input int ackd, input int addd);
    int l, r, stop_cyc;
    logic valid, is_cmp, ovf, wr;
    logic [30:0] v, op1, op2, res;
    logic [1:0] cmp_exp;
    logic [6:0] exp_s;
    l = int'(f[5:3]);
    r = int'(f[2:0]);
    is_cmp = (cmd == 6'd56);
    valid  = (l <= r) && (r <= 5) && (cmd == 6'd1 || cmd == 6'd2 || (CMPEN && is_cmp));
    v   = fld(memw, l, r);
    op2 = (cmd == 6'd1) ? v : {~v[30], v[29:0]};
    op1 = is_cmp ? fld(ra, l, r) : ra;
    sm_add(op1, op2, res, ovf);
    cmp_exp  = (res[29:0] == 30'd0) ? 2'b10 : (res[30] ? 2'b01 : 2'b11);
    stop_cyc = valid ? 4 + ackd + addd : 1;

    @(posedge clk); #1;
    start = 1'b1; command = cmd; field = f; address = addr; ra_in = ra;
    mem_ack = 1'b0; add_stop = 1'b0;
    mem_data = 31'($urandom); add_out = 31'($urandom); add_overflow = 1'b0;
    #1 chk($sformatf("%s c0 strobes", tag), {25'd0, strobes()}, 32'd0);

    for (int c = 1; c <= stop_cyc + 1; c++) begin
      @(posedge clk); #1;
      start    = (c <= stop_cyc);
      command  = 6'($urandom);
      field    = 6'($urandom);
      address  = 12'($urandom);
      mem_ack  = valid && (c == 1 + ackd);
      mem_data = mem_ack ? memw : 31'($urandom);
      add_stop = valid && (c == 3 + ackd + addd);
      add_out  = add_stop ? res : 31'($urandom);
      add_overflow = add_stop ? ovf : 1'($urandom);
      #1;
      wr = valid && (c == 3 + ackd + addd);
      exp_s = {valid && c <= 1 + ackd, valid && c == 2 + ackd, wr && !is_cmp,
               wr && !is_cmp && ovf, wr && is_cmp, c == stop_cyc, c == stop_cyc && !valid};
      chk($sformatf("%s c%0d strobes", tag, c), {25'd0, strobes()}, {25'd0, exp_s});
      if (valid && c <= 1 + ackd)
        chk($sformatf("%s c%0d mem_addr", tag, c), {20'd0, mem_addr}, {20'd0, addr});
      if (valid && c >= 2 + ackd && c <= 3 + ackd + addd) begin
        chk($sformatf("%s c%0d add_in1", tag, c), {1'b0, add_in1}, {1'b0, op1});
        chk($sformatf("%s c%0d add_in2", tag, c), {1'b0, add_in2}, {1'b0, op2});
      end
      if (wr && !is_cmp)
        chk($sformatf("%s c%0d ra_out", tag, c), {1'b0, ra_out}, {1'b0, res});
`ifdef ARITH_CMP_EN
      if (wr && is_cmp)
        chk($sformatf("%s c%0d cmp_out", tag, c), {30'd0, cmp_out}, {30'd0, cmp_exp});
`endif
    end
    start = 1'b0; mem_ack = 1'b0; add_stop = 1'b0;
    $display("txn %-8s cmd=%0d F=%0d ra=%h mem=%h valid=%0d ackd=%0d addd=%0d res=%h ovf=%0d cmp=%b",
             tag, cmd, f, ra, memw, valid, ackd, addd, res, ovf, cmp_exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " strobes"}, {25'd0, strobes()}, 32'd0);
    chk({tag, " mem_addr"}, {20'd0, mem_addr}, 32'd0);
    chk({tag, " add_in1"}, {1'b0, add_in1}, 32'd0);
    chk({tag, " add_in2"}, {1'b0, add_in2}, 32'd0);
    chk({tag, " ra_out"}, {1'b0, ra_out}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; command = '0; field = '0; address = '0;
    mem_ack = 1'b0; mem_data = '0; add_stop = 1'b0; add_out = '0; add_overflow = 1'b0;
    ra_in = '0;
    #2 chk_all_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    run("add",    6'd1, 6'd5,  12'h123, {1'b0, 30'd100}, {1'b0, 30'd23}, 0, 0);
    run("sub",    6'd2, 6'd5,  12'h456, {1'b0, 30'd10},  {1'b0, 30'd30}, 0, 0);
    run("ovf",    6'd1, 6'd5,  12'h001, {1'b0, 30'h3FFF_FFFF}, {1'b0, 30'd1}, 0, 0);
    run("f1_5",   6'd1, 6'd13, 12'h010, {1'b0, 30'd0}, {1'b1, 30'd7}, 0, 0);
    run("f5_5",   6'd1, 6'd45, 12'h020, {1'b0, 30'd0},
        {1'b0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd9}, 0, 0);
    run("f0_0",   6'd2, 6'd0,  12'h030, {1'b1, 30'd55}, {1'b1, 30'h3FFF_FFFF}, 1, 0);
    run("bad_lr", 6'd1, 6'd33, 12'h040, {1'b0, 30'd1}, {1'b0, 30'd1}, 0, 0);
    run("bad_r6", 6'd1, 6'd6,  12'h050, {1'b0, 30'd1}, {1'b0, 30'd1}, 0, 0);
    run("bad_cmd", 6'd3, 6'd5, 12'h060, {1'b0, 30'd1}, {1'b0, 30'd1}, 0, 0);
    run("ack3",   6'd1, 6'd5,  12'hABC, {1'b0, 30'd4}, {1'b0, 30'd5}, 3, 0);
    run("cmpa0",  6'd56, 6'd5, 12'h070, {1'b0, 30'd0}, {1'b1, 30'd0}, 0, 0);
    run("cmpa_lt", 6'd56, 6'd5, 12'h071, {1'b0, 30'd5}, {1'b0, 30'd9}, 0, 1);
    run("cmpa_gt", 6'd56, 6'd5, 12'h072, {1'b1, 30'd5}, {1'b1, 30'd9}, 1, 0);

    for (int i = 0; i < 40; i++) begin
      int sel, l, r;
      logic [5:0] cmd, f;
      sel = $urandom_range(0, 9);
      cmd = (sel < 4) ? 6'd1 : (sel < 8) ? 6'd2 : (sel == 8) ? 6'd56 : 6'($urandom_range(0, 63));
      l = $urandom_range(0, 5);
      r = $urandom_range(l, 5);
      f = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'(l * 8 + r);
      run("rnd", cmd, f, 12'($urandom), 31'($urandom), 31'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Reset while waiting on the adder abandons the instruction.
    @(posedge clk); #1;
    start = 1'b1; command = 6'd1; field = 6'd5; address = 12'h7FF; ra_in = {1'b0, 30'd3};
    @(posedge clk); #1;
    start = 1'b0; mem_ack = 1'b1; mem_data = {1'b0, 30'd4};
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    #1 chk("rst wait add_in1", {1'b0, add_in1}, {1'b0, 30'd3});
    reset = 1'b1;
    #1 chk_all_zero("rst mid");
    @(posedge clk); #1;
    add_stop = 1'b1; add_out = {1'b0, 30'd7};
    #1 chk_all_zero("rst held");
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #2;
      chk($sformatf("post rst c%0d strobes", c), {25'd0, strobes()}, 32'd0);
    end
    add_stop = 1'b0;
    $display("txn rst_wait reset during WAIT, no completion afterwards");
    run("after", 6'd2, 6'd13, 12'h0F0, {1'b1, 30'd100}, {1'b0, 30'd1000}, 2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
